// File: rtl/moving_average.sv
// Streaming boxcar averager: running window sum fed by the current sample and
// the sample leaving the window, with truncated mean, valid and per-sample strobe.
module moving_average #(
    parameter int N        = 8,
    parameter int LOG2_LEN = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  clr,
    input  logic [N-1:0]          i_data,
    input  logic [N-1:0]          i_delayed,
    output logic [N+LOG2_LEN-1:0] o_sum,
    output logic [N-1:0]          o_avg,
    output logic                  o_valid,
    output logic                  o_strobe
);

    localparam int SW  = N + LOG2_LEN;
    localparam int CW  = LOG2_LEN + 1;
    localparam int LEN = 1 << LOG2_LEN;
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [SW-1:0] data_ext;
    logic [SW-1:0] dly_ext;
    logic [SW-1:0] next_sum;

    assign data_ext = {{LOG2_LEN{1'b0}}, i_data};
    assign dly_ext  = {{LOG2_LEN{1'b0}}, i_delayed};

    // During FILL the delay line still holds stale/unreset data, so it is ignored.
    always_comb begin
        next_sum = o_sum + data_ext;
        if (state == RUN)
            next_sum = o_sum + data_ext - dly_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FILL;
            count    <= '0;
            o_sum    <= '0;
            o_avg    <= '0;
            o_valid  <= 1'b0;
            o_strobe <= 1'b0;
        end else if (clr) begin
            state    <= FILL;
            count    <= '0;
            o_sum    <= '0;
            o_avg    <= '0;
            o_valid  <= 1'b0;
            o_strobe <= 1'b0;
        end else if (ce) begin
            o_sum    <= next_sum;
            o_avg    <= next_sum[SW-1:LOG2_LEN];
            o_strobe <= (state == RUN) || (count == LAST);
            if (state == FILL) begin
                count <= count + 1'b1;
                if (count == LAST) begin
                    state   <= RUN;
                    o_valid <= 1'b1;
                end
            end
        end else begin
            o_strobe <= 1'b0;
        end
    end

endmodule
